// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: sends a table of N_CMD configuration words to a single I2C
// slave. Each word is a 3-byte write {DEV_ADDR,W}, cmd_data[15:8],
// cmd_data[7:0] framed by START/STOP. All bus timing advances on a divider
// tick (one tick = one SCLK quarter-period = CLK_DIV clk cycles).
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     one-cycle pulse, starts a sequence from word 0 when idle
//   cmd_idx   index of the word currently requested/sent
//   cmd_data  word for cmd_idx from an external table, {reg[6:0], data[8:0]}
//   I2C_SCLK  I2C clock, push-pull
//   I2C_SDAT  I2C data, open-drain (0 or Z only)
//   busy      sequence in progress
//   done      all words ACKed (held until the next accepted start)
//   error     unrecoverable NACK (held until the next accepted start)
//
// Build option: define I2C_RETRY_EN to re-send a NACKed word up to
// MAX_RETRY times before giving up; otherwise the first NACK is fatal.
module i2c_cfg_seq #(
  parameter int         N_CMD      = 7,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         CLK_DIV    = 4,
  parameter int         MAX_RETRY  = 3,
  parameter int         AUTO_START = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  cmd_idx,
  input  logic [15:0] cmd_data,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_NEXT, S_FINISH, S_FAIL
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_q;        // quarter-period within the current phase
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic [23:0]        r_shift;
  logic               r_sda_low;
  logic               r_scl;
  logic [7:0]         r_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_nack;
  logic               r_armed;    // blocks a start seen on the reset-release edge
`ifdef I2C_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0]   r_retry;
`else
  // MAX_RETRY has no effect without retry support.
  if (MAX_RETRY < 0) begin : g_max_retry_unused
  end
`endif

  logic w_tick;
  logic w_go;
  logic w_sda_in;

  assign w_tick   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_go     = r_armed ? start : (AUTO_START != 0);
  assign w_sda_in = I2C_SDAT;

  assign I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;
  assign I2C_SCLK = r_scl;
  assign cmd_idx  = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
      r_sda_low <= 1'b0;
      r_scl     <= 1'b1;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_nack    <= 1'b0;
      r_armed   <= 1'b0;
`ifdef I2C_RETRY_EN
      r_retry   <= '0;
`endif
    end else begin
      r_armed <= 1'b1;
      // Divider runs only during bus phases so every phase starts tick-aligned.
      if (r_state == S_START || r_state == S_BIT || r_state == S_ACK || r_state == S_STOP)
        r_div <= w_tick ? '0 : r_div + 1'b1;
      else
        r_div <= '0;

      case (r_state)
        S_IDLE: begin
          r_scl     <= 1'b1;
          r_sda_low <= 1'b0;
          if (w_go) begin
            r_state <= S_START;
            r_q     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef I2C_RETRY_EN
            r_retry <= '0;
`endif
          end
        end
        S_START: begin
          // cmd_idx is stable for the whole phase, so reload every cycle.
          r_shift <= {DEV_ADDR, 1'b0, cmd_data};
          r_byte  <= '0;
          r_bit   <= '0;
          r_nack  <= 1'b0;
          if (w_tick) begin
            if (r_q == 2'd0) begin
              r_sda_low <= 1'b1;
              r_q       <= 2'd1;
            end else begin
              // SCLK falls and the first data bit is set on the same edge.
              r_scl     <= 1'b0;
              r_sda_low <= ~r_shift[23];
              r_q       <= 2'd0;
              r_state   <= S_BIT;
            end
          end
        end
        S_BIT: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd1) r_scl <= 1'b1;
            if (r_q == 2'd3) begin
              r_scl   <= 1'b0;
              r_shift <= {r_shift[22:0], 1'b0};
              if (r_bit == 3'd7) begin
                r_sda_low <= 1'b0;
                r_state   <= S_ACK;
              end else begin
                r_bit     <= r_bit + 3'd1;
                r_sda_low <= ~r_shift[22];
              end
            end
          end
        end
        S_ACK: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd1) r_scl <= 1'b1;
            // Mid-high sample; a released line (pulled up) reads as NACK.
            if (r_q == 2'd2) r_nack <= w_sda_in;
            if (r_q == 2'd3) begin
              r_scl <= 1'b0;
              r_bit <= '0;
              if (r_nack || r_byte == 2'd2) begin
                r_sda_low <= 1'b1;
                r_state   <= S_STOP;
              end else begin
                r_byte    <= r_byte + 2'd1;
                r_sda_low <= ~r_shift[23];
                r_state   <= S_BIT;
              end
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd1) r_scl <= 1'b1;
            if (r_q == 2'd2) r_sda_low <= 1'b0;
            if (r_q == 2'd3) begin
              if (!r_nack) begin
                r_state <= S_NEXT;
              end else begin
`ifdef I2C_RETRY_EN
                if (r_retry < RTY_W'(MAX_RETRY)) begin
                  r_retry <= r_retry + 1'b1;
                  r_state <= S_START;
                end else begin
                  r_state <= S_FAIL;
                end
`else
                r_state <= S_FAIL;
`endif
              end
            end
          end
        end
        S_NEXT: begin
`ifdef I2C_RETRY_EN
          r_retry <= '0;
`endif
          r_q <= '0;
          if (r_idx == 8'(N_CMD - 1)) begin
            r_state <= S_FINISH;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_START;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Testbench for i2c_cfg_seq: randomized word tables and NACK plans, an I2C
// bus decoder/slave model on the wires, and a transaction-level model of
// the expected byte stream and final status.
module tb_i2c_cfg_seq;

  localparam int N_CMD     = 7;
  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 2;
  localparam int SCL_PER   = 4 * CLK_DIV;
`ifdef I2C_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd_idx;
  logic [15:0] cmd_data;
  logic        scl, busy, done, error;
  logic        sl_low = 1'b0;
  wire         sda;

  assign sda = sl_low ? 1'b0 : 1'bz;
  pullup (sda);

  logic [15:0] tbl [0:7];
  assign cmd_data = tbl[cmd_idx[2:0]];

  always #5 clk = ~clk;

  i2c_cfg_seq #(.N_CMD(N_CMD), .DEV_ADDR(7'h1A), .CLK_DIV(CLK_DIV),
                .MAX_RETRY(MAX_RETRY), .AUTO_START(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .I2C_SCLK(scl), .I2C_SDAT(sda), .busy(busy), .done(done), .error(error));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          nb;
    logic [23:0] data;
    logic        nack;
  } txn_t;

  txn_t obs_q[$];
  txn_t exp_q[$];

  // Bus decoder + slave, all state owned by this process.
  int   cyc = 0, n_rise = 0, n_stop = 0, n_start = 0, viol = 0, per_err = 0, nack_given = 0;
  int   bit_cnt = 0, byte_cnt = 0, last_rise = 0;
  logic p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0, has_rise = 1'b0, fnack = 1'b0, nk;
  logic [7:0]  sh = '0;
  logic [23:0] fdata = '0;
  txn_t t;

  // NACK plan, owned by the stimulus process.
  int plan_word = -1, plan_byte = 0, plan_count = 0, plan_base = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        in_frame = 1'b0; bit_cnt = 0; byte_cnt = 0; has_rise = 1'b0; sl_low = 1'b0;
      end else if (p_scl && scl && p_sda && !sda) begin
        n_start++;
        if (in_frame) viol++;
        in_frame = 1'b1; bit_cnt = 0; byte_cnt = 0; fdata = '0; fnack = 1'b0; has_rise = 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        n_stop++;
        // The STOP's own SCLK rise was taken as bit 0 of a next byte.
        if (!in_frame || bit_cnt != 1) viol++;
        if (in_frame) begin
          t.nb = byte_cnt; t.data = fdata; t.nack = fnack;
          obs_q.push_back(t);
        end
        in_frame = 1'b0; bit_cnt = 0;
      end else if (!p_scl && scl) begin
        n_rise++;
        if (!in_frame) viol++;
        if (has_rise && (cyc - last_rise) != SCL_PER) per_err++;
        has_rise = 1'b1; last_rise = cyc;
        if (bit_cnt < 8) begin
          sh = {sh[6:0], sda};
          bit_cnt++;
        end else begin
          if (sda) fnack = 1'b1;
          if (byte_cnt < 3) fdata[23 - 8*byte_cnt -: 8] = sh;
          byte_cnt++;
          bit_cnt = 0;
        end
      end else if (p_scl && !scl) begin
        if (in_frame && bit_cnt == 8) begin
          nk = (int'(cmd_idx) == plan_word) && (byte_cnt == plan_byte) &&
               ((nack_given - plan_base) < plan_count);
          if (nk) nack_given++;
          sl_low = !nk;
        end else begin
          sl_low = 1'b0;
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  // Reference model: which transactions appear and how the sequence ends.
  logic exp_done, exp_err;
  int   exp_idx;

  task automatic build_exp(input int w, input int b, input int k);
    int   left;
    int   att;
    logic fail;
    txn_t e;
    exp_q.delete();
    left = k; fail = 1'b0; exp_idx = 0;
    for (int i = 0; i < N_CMD && !fail; i++) begin
      att = 0;
      exp_idx = i;
      for (int a = 0; a < 16; a++) begin
        if (i == w && left > 0) begin
          e.nb = b + 1;
          e.data = {8'h34, tbl[i]} & (24'hFFFFFF << (8 * (2 - b)));
          e.nack = 1'b1;
          exp_q.push_back(e);
          left--; att++;
          if (!(RETRY && att <= MAX_RETRY)) begin
            fail = 1'b1;
            break;
          end
        end else begin
          e.nb = 3; e.data = {8'h34, tbl[i]}; e.nack = 1'b0;
          exp_q.push_back(e);
          break;
        end
      end
    end
    exp_done = !fail;
    exp_err  = fail;
  endtask

  int rd, s_rise, s_stop, s_start, s_viol, s_per;

  task automatic snapshot();
    rd = obs_q.size(); s_rise = n_rise; s_stop = n_stop; s_start = n_start;
    s_viol = viol; s_per = per_err;
  endtask

  task automatic new_table();
    for (int i = 0; i < 8; i++) tbl[i] = 16'($urandom);
  endtask

  task automatic set_plan(input int w, input int b, input int k);
    plan_word = w; plan_byte = b; plan_count = k; plan_base = nack_given;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 12000 && !ok; i++) begin
      @(negedge clk);
      if (!busy && (done || error)) ok = 1'b1;
    end
    check_eq({tag, "_finished"}, ok, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_result(input string tag);
    int nobs;
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_error"}, error, exp_err);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_cmd_idx"}, cmd_idx, exp_idx);
    check_eq({tag, "_sda_idle"}, sda, 1'b1);
    check_eq({tag, "_scl_idle"}, scl, 1'b1);
    nobs = obs_q.size() - rd;
    check_eq({tag, "_txn_count"}, nobs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
      check_eq($sformatf("%s_txn%0d_data", tag, i), obs_q[rd + i].data, exp_q[i].data);
      check_eq($sformatf("%s_txn%0d_nbytes", tag, i), obs_q[rd + i].nb, exp_q[i].nb);
      check_eq($sformatf("%s_txn%0d_nack", tag, i), obs_q[rd + i].nack, exp_q[i].nack);
    end
    check_eq({tag, "_bus_viol"}, viol - s_viol, 0);
    check_eq({tag, "_scl_period"}, per_err - s_per, 0);
  endtask

  task automatic run_nack(input string tag, input int w, input int b, input int k);
    new_table();
    set_plan(w, b, k);
    build_exp(w, b, k);
    snapshot();
    pulse_start();
    check_eq({tag, "_busy_after_start"}, busy, 1'b1);
    wait_end(tag);
    check_result(tag);
  endtask

  int  t0, lat, nom;
  logic ok_lat;

  initial begin
    new_table();
    repeat (3) @(negedge clk);
    check_eq("rst_scl", scl, 1'b1);
    check_eq("rst_sda", sda, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_cmd_idx", cmd_idx, 8'd0);

    // Auto-started sequence, all ACKs, with a start pulse while busy.
    set_plan(-1, 0, 0);
    build_exp(-1, 0, 0);
    snapshot();
    rst = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check_eq("auto_busy", busy, 1'b1);
    repeat (400 + $urandom_range(0, 600)) @(negedge clk);
    check_eq("busy_mid", busy, 1'b1);
    pulse_start();
    wait_end("auto");
    lat = cyc - t0 - 4;
    nom = N_CMD * (29 * SCL_PER + 1);
    ok_lat = (lat >= nom - 2 * SCL_PER * N_CMD) && (lat <= nom + 2 * SCL_PER * N_CMD);
    check_eq("auto_latency_in_window", ok_lat, 1'b1);
    check_result("auto");
    check_eq("auto_scl_pulses", (n_rise - s_rise) - (n_stop - s_stop), 189);
    check_eq("auto_starts", n_start - s_start, N_CMD);

    // Restart after done.
    new_table();
    build_exp(-1, 0, 0);
    snapshot();
    pulse_start();
    check_eq("restart_done_cleared", done, 1'b0);
    check_eq("restart_busy", busy, 1'b1);
    check_eq("restart_cmd_idx", cmd_idx, 8'd0);
    wait_end("restart");
    check_result("restart");

    // NACK handling.
    run_nack("nack_w3b1", 3, 1, 1);
    run_nack("nack_w3b2x2", 3, 2, 2);
    run_nack("nack_w3b2x3", 3, 2, 3);
    for (int r = 0; r < 3; r++)
      run_nack($sformatf("nack_rand%0d", r), $urandom_range(0, N_CMD - 1),
               $urandom_range(0, 2), $urandom_range(1, 3));

    // Reset in the middle of a byte of word 2.
    new_table();
    set_plan(-1, 0, 0);
    pulse_start();
    for (int i = 0; i < 5000 && cmd_idx != 8'd2; i++) @(negedge clk);
    check_eq("mid_reached_word2", cmd_idx, 8'd2);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("mid_rst_scl", scl, 1'b1);
    check_eq("mid_rst_sda", sda, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_cmd_idx", cmd_idx, 8'd0);
    repeat (3) @(negedge clk);
    build_exp(-1, 0, 0);
    snapshot();
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_restart_busy", busy, 1'b1);
    check_eq("mid_restart_cmd_idx", cmd_idx, 8'd0);
    wait_end("mid_restart");
    check_result("mid_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
